// File: rtl/ssram_arbiter_pkg.sv
// ssram_arbiter_pkg: shared definitions for the two-port SSRAM arbiter.
//   owner_e             - lock-ownership state (IDLE=0, OWN0=1, OWN1=2)
//   STARVE_LIMIT_DFLT   - default denied-cycle count before port 1 is forced
//   STARVE_W            - width of the starvation counter
package ssram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } owner_e;

  localparam int unsigned STARVE_LIMIT_DFLT = 4;
  localparam int unsigned STARVE_W          = 4;

endpackage : ssram_arbiter_pkg

// File: rtl/ssram_arbiter.sv
// ssram_arbiter: arbitrates two requesters onto one synchronous SRAM port.
//   Port 0 carries AHB-bridge traffic, port 1 carries DMA/debug traffic.
//   Priority: lock owner > starved port 1 > port 0 > port 1.
//   Ports:
//     HCLK, HRESETn           - clock, asynchronous active-low reset
//     pN_req/lock/we/addr/wb/din (N=0,1) - request side
//     pN_gnt                  - combinational accept
//     pN_rvalid/pN_dout       - read return, one cycle after a read grant
//     sram_en/we/addr/enb/wb/din, sram_dout - SRAM side
module ssram_arbiter
  import ssram_arbiter_pkg::*;
#(
  parameter int unsigned AW           = 12,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DFLT
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          p0_req,
  input  logic          p0_lock,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [3:0]    p0_wb,
  input  logic [31:0]   p0_din,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [31:0]   p0_dout,
  input  logic          p1_req,
  input  logic          p1_lock,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [3:0]    p1_wb,
  input  logic [31:0]   p1_din,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [31:0]   p1_dout,
  output logic          sram_en,
  output logic          sram_we,
  output logic [AW-1:0] sram_addr,
  output logic [3:0]    sram_enb,
  output logic [3:0]    sram_wb,
  output logic [31:0]   sram_din,
  input  logic [31:0]   sram_dout
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  owner_e              owner_q, owner_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                rvalid0_q, rvalid0_d;
  logic                rvalid1_q, rvalid1_d;

  // Grant and next-state. An owner that drops its request in OWNN gets no
  // grant that cycle and the other port stays blocked until IDLE is reached.
  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    unique case (owner_q)
      OWN0: p0_gnt = p0_req;
      OWN1: p1_gnt = p1_req;
      default: begin
        if (p1_req && (starve_q == LIMIT)) p1_gnt = 1'b1;
        else if (p0_req)                   p0_gnt = 1'b1;
        else if (p1_req)                   p1_gnt = 1'b1;
      end
    endcase

    // Ownership persists only while the owner is granted with lock held.
    owner_d = IDLE;
    if (p0_gnt && p0_lock)      owner_d = OWN0;
    else if (p1_gnt && p1_lock) owner_d = OWN1;

    starve_d = starve_q;
    if (!p1_req || p1_gnt)    starve_d = '0;
    else if (starve_q < LIMIT) starve_d = starve_q + 1'b1;

    rvalid0_d = p0_gnt && !p0_we;
    rvalid1_d = p1_gnt && !p1_we;
  end

  // SRAM mux; address/data default to port 0 when nobody is granted.
  always_comb begin
    sram_en   = p0_gnt | p1_gnt;
    sram_we   = 1'b0;
    sram_enb  = '0;
    sram_addr = p0_addr;
    sram_din  = p0_din;
    if (p1_gnt) begin
      sram_we   = p1_we;
      sram_enb  = p1_wb;
      sram_addr = p1_addr;
      sram_din  = p1_din;
    end else if (p0_gnt) begin
      sram_we   = p0_we;
      sram_enb  = p0_wb;
    end
    sram_wb = sram_enb & {4{sram_we}};
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      owner_q   <= IDLE;
      starve_q  <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      owner_q   <= owner_d;
      starve_q  <= starve_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  assign p0_rvalid = rvalid0_q;
  assign p1_rvalid = rvalid1_q;
  assign p0_dout   = sram_dout;
  assign p1_dout   = sram_dout;

endmodule : ssram_arbiter
